// File: rtl/rx_block_lock_pkg.sv
// -----------------------------------------------------------------------------
// rx_block_lock_pkg
// Shared PCS definitions for the 64b/66b receive block-lock logic.
//   blk_lock_state_t : block-lock FSM states (HUNT, LOCKED, SLIP)
//   SYNC_DATA        : sync header of a data block (2'b01)
//   SYNC_CTRL        : sync header of a control block (2'b10)
//   is_valid_hdr()   : 1 when a 2-bit sync header is a legal 64b/66b header
// -----------------------------------------------------------------------------
package rx_block_lock_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1,
    SLIP   = 2'd2
  } blk_lock_state_t;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Only the two transitions-carrying patterns are legal; 00/11 mean the
  // gearbox is aligned on the wrong bit.
  function automatic logic is_valid_hdr(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/rx_block_lock.sv
// -----------------------------------------------------------------------------
// rx_block_lock
// Receive-side 64b/66b block-lock FSM (32-bit datapath). Watches the sync
// headers coming out of the RX gearbox, declares block lock after LOCK_CNT
// consecutive valid headers, drops lock when INVALID_MAX invalid headers land
// inside one LOCK_CNT-header window, and requests single-bit gearbox slips.
//
// Ports
//   i_clk            in   clock
//   i_reset_n        in   asynchronous active-low reset
//   i_rx_hdr         in   sync header from the gearbox
//   i_rx_hdr_valid   in   i_rx_hdr belongs to the current word
//   i_rx_data_valid  in   gearbox word valid
//   o_block_lock     out  block lock achieved (to decoder i_block_lock)
//   o_slip           out  single-cycle bitslip request to the gearbox
//   o_slip_cnt       out  saturating number of slips since reset (debug)
//   o_state          out  current FSM state (debug)
//
// Handshake: a header is consumed on a rising edge only when
// i_rx_hdr_valid && i_rx_data_valid; there is no back-pressure, the gearbox
// must simply present the header for that one cycle.
// -----------------------------------------------------------------------------
module rx_block_lock
  import rx_block_lock_pkg::*;
#(
  parameter int HDR_WIDTH   = 2,
  parameter int LOCK_CNT    = 64,
  parameter int INVALID_MAX = 16,
  parameter int SLIP_WAIT   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [HDR_WIDTH-1:0] i_rx_hdr,
  input  logic                 i_rx_hdr_valid,
  input  logic                 i_rx_data_valid,
  output logic                 o_block_lock,
  output logic                 o_slip,
  output logic [7:0]           o_slip_cnt,
  output blk_lock_state_t      o_state
);

  localparam int SH_W   = $clog2(LOCK_CNT + 1);
  localparam int INV_W  = $clog2(INVALID_MAX + 1);
  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  localparam logic [SH_W-1:0]   SH_FULL   = SH_W'(LOCK_CNT);
  localparam logic [INV_W-1:0]  INV_FULL  = INV_W'(INVALID_MAX);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  blk_lock_state_t   r_state;
  logic [SH_W-1:0]   r_sh_cnt;
  logic [INV_W-1:0]  r_inv_cnt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_block_lock;
  logic              r_slip;
  logic [7:0]        r_slip_cnt;

  logic              w_sample;
  logic              w_hdr_ok;
  logic [SH_W-1:0]   w_sh_next;
  logic [INV_W-1:0]  w_inv_next;

  assign w_sample   = i_rx_hdr_valid && i_rx_data_valid;
  assign w_hdr_ok   = is_valid_hdr(i_rx_hdr[1:0]);
  assign w_sh_next  = r_sh_cnt + SH_W'(1);
  assign w_inv_next = r_inv_cnt + {{(INV_W-1){1'b0}}, ~w_hdr_ok};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= HUNT;
      r_sh_cnt     <= '0;
      r_inv_cnt    <= '0;
      r_wait_cnt   <= '0;
      r_block_lock <= 1'b0;
      r_slip       <= 1'b0;
      r_slip_cnt   <= '0;
    end else begin
      r_slip <= 1'b0;
      case (r_state)
        HUNT: begin
          if (w_sample) begin
            if (w_hdr_ok) begin
              if (w_sh_next == SH_FULL) begin
                r_state      <= LOCKED;
                r_block_lock <= 1'b1;
                r_sh_cnt     <= '0;
                r_inv_cnt    <= '0;
              end else begin
                r_sh_cnt <= w_sh_next;
              end
            end else begin
              r_state    <= SLIP;
              r_slip     <= 1'b1;
              r_sh_cnt   <= '0;
              r_inv_cnt  <= '0;
              r_wait_cnt <= '0;
              if (r_slip_cnt != 8'hFF) r_slip_cnt <= r_slip_cnt + 8'd1;
            end
          end
        end

        LOCKED: begin
          if (w_sample) begin
            // Loss of lock is tested first so it wins when the last
            // invalid header is also the last header of the window.
            if (w_inv_next == INV_FULL) begin
              r_state      <= SLIP;
              r_block_lock <= 1'b0;
              r_slip       <= 1'b1;
              r_sh_cnt     <= '0;
              r_inv_cnt    <= '0;
              r_wait_cnt   <= '0;
              if (r_slip_cnt != 8'hFF) r_slip_cnt <= r_slip_cnt + 8'd1;
            end else if (w_sh_next == SH_FULL) begin
              r_sh_cnt  <= '0;
              r_inv_cnt <= '0;
            end else begin
              r_sh_cnt  <= w_sh_next;
              r_inv_cnt <= w_inv_next;
            end
          end
        end

        SLIP: begin
          // Runs on every clock, regardless of data valid, so the gearbox
          // gets a fixed settling time after each slip.
          if (r_wait_cnt == WAIT_LAST) begin
            r_state    <= HUNT;
            r_wait_cnt <= '0;
            r_sh_cnt   <= '0;
            r_inv_cnt  <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end

        default: begin
          r_state      <= HUNT;
          r_block_lock <= 1'b0;
          r_sh_cnt     <= '0;
          r_inv_cnt    <= '0;
          r_wait_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_block_lock = r_block_lock;
  assign o_slip       = r_slip;
  assign o_slip_cnt   = r_slip_cnt;
  assign o_state      = r_state;

endmodule

// File: doc/rx_block_lock.md
# rx_block_lock

Receive-side 64b/66b block-lock state machine for the 10G PCS, following the IEEE 802.3 Clause 49 lock procedure on the 32-bit datapath. It sits between the RX gearbox and `xgmii_decoder`:

- It inspects each 2-bit sync header delivered alongside the 32-bit data words.
- It declares block lock after a run of valid headers and drives `xgmii_decoder.i_block_lock`.
- It requests a one-bit gearbox slip whenever alignment is wrong or lost.

It is the receive counterpart of the encoder's sync-header insertion.

## Interface
Parameters:
- `HDR_WIDTH`, 2, sync header width.
- `LOCK_CNT`, 64, number of consecutive valid headers needed to acquire lock; also the monitoring window length while locked.
- `INVALID_MAX`, 16, number of invalid headers within one window that causes loss of lock.
- `SLIP_WAIT`, 32, number of `i_clk` cycles headers are ignored after a slip request.

Ports:
- `i_clk`  in  1  clock.
- `i_reset_n`  in  1  reset; asynchronous assert, active-low.
- `i_rx_hdr`  in  `HDR_WIDTH`  sync header from the gearbox.
- `i_rx_hdr_valid`  in  1  `i_rx_hdr` belongs to the current word; high on every other word of the 32-bit datapath.
- `i_rx_data_valid`  in  1  gearbox word valid.
- `o_block_lock`  out  1  block lock achieved; drives the decoder's `i_block_lock`.
- `o_slip`  out  1  single-cycle bitslip request to the gearbox.
- `o_slip_cnt`  out  8  saturating count of slips since reset (debug).

## Operation
- **Header sample.** A header is sampled on a rising `i_clk` edge where `i_rx_hdr_valid && i_rx_data_valid`.
  - Valid header: `2'b01` (data) or `2'b10` (control).
  - Invalid header: `2'b00` or `2'b11`.
- **Counters.**
  - `sh_cnt` is `$clog2(LOCK_CNT+1)` bits wide.
  - `inv_cnt` is `$clog2(INVALID_MAX+1)` bits wide.
  - Both are cleared on every state change and at each window end.
- **HUNT** (reset state, `o_block_lock=0`):
  - Valid sample: increment `sh_cnt`. The sample that brings `sh_cnt` to `LOCK_CNT` moves the FSM to LOCKED, sets `o_block_lock=1` and clears the counters.
  - Invalid sample: pulse `o_slip`, go to SLIP.
- **LOCKED** (`o_block_lock=1`):
  - Every sample increments `sh_cnt`. Invalid samples also increment `inv_cnt`.
  - When `inv_cnt` reaches `INVALID_MAX`: clear `o_block_lock`, pulse `o_slip`, go to SLIP.
  - Otherwise, when `sh_cnt` reaches `LOCK_CNT`: clear both counters and stay LOCKED.
  - If both conditions occur on the same sample (the 16th invalid is the 64th header), loss of lock wins.
- **SLIP** (`o_block_lock=0`):
  - A wait counter counts `SLIP_WAIT` `i_clk` cycles. Headers are ignored throughout.
  - The FSM then goes to HUNT.
  - No further slip is issued during the wait.
- **Slip count.** `o_slip_cnt` increments on each `o_slip` pulse and saturates at 255.
- **Idle input.** With `i_rx_data_valid` low, no sample is taken. Counters and state hold, except that the SLIP wait counter continues to run.

## Timing
- All outputs are registered.
- Reset values: `o_block_lock=0`, `o_slip=0`, `o_slip_cnt=0`, state HUNT, all counters 0.
- Lock latency: `o_block_lock` rises on the edge that samples the `LOCK_CNT`-th consecutive valid header. It is visible in the following cycle.
- Slip latency: `o_slip` is high for exactly one cycle, starting at the edge that samples the offending header. `o_block_lock` falls on that same edge.
- Re-entry to HUNT occurs `SLIP_WAIT` cycles after the `o_slip` edge. The first header eligible for sampling is at the next edge after re-entry.
- Asserting reset mid-operation clears all outputs immediately (asynchronously), regardless of state.

## Structure
- Put the following in the shared PCS package used by the encoder and decoder:
  - State enum `blk_lock_state_t` {HUNT, LOCKED, SLIP}.
  - Constants `SYNC_DATA=2'b01` and `SYNC_CTRL=2'b10`.
  - Function `is_valid_hdr()`.
- Single flat module; no sub-module is warranted.

## Test plan
- **Acquire lock.** Drive 64 `2'b01`/`2'b10` headers with `hdr_valid` toggling every cycle.
  - `o_block_lock` = 1 one cycle after the 64th sample (clock 128 after reset release).
  - `o_slip` never asserted.
- **Slip while hunting.** Drive 63 valid headers, then `2'b11`.
  - `o_slip` pulses for 1 cycle, `o_slip_cnt=1`, no lock.
  - Headers are ignored for 32 cycles, after which a fresh 64-header run achieves lock.
- **Tolerance window.** While locked, put 15 invalid headers inside a 64-header window, repeated for 3 windows.
  - `o_block_lock` stays 1 and `o_slip` is never asserted.
- **Loss of lock.** While locked, drive 16 invalid headers within one window, the last at sample 64.
  - `o_block_lock` falls and `o_slip` pulses on that edge.
  - `o_slip_cnt` increments.
- **Reset and gating.**
  - Assert `i_reset_n=0` while LOCKED mid-window: all outputs 0 with no clock edge.
  - Hold `i_rx_data_valid=0` for 20 cycles mid-hunt: `sh_cnt` holds, and lock then arrives after the remaining headers.
- **Encoder loopback.** Connect encoder `o_tx_sync_hdr`/`o_tx_data_valid` with a toggling `hdr_valid` into `rx_block_lock` and the decoder.
  - Lock asserts after 64 headers.
  - The decoder output then matches the XGMII stimulus word for word.
